regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive cycles a pending load may lose arbitration.
REQ-002 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports issue_valid/issue_vec/issue_dst  input  1/1/4  destination reservation request (vector or scalar, register index).
REQ-005 SHALL have port issue_ready  output  1  reservation accepted this cycle.
REQ-006 SHALL have ports chk_vec/chk_ra1/chk_ra2  input  1/4/4  read-operand hazard query.
REQ-007 SHALL have port hazard  output  1  combinational; either queried source is busy.
REQ-008 SHALL have ports alu_valid/alu_vec/alu_cmd/alu_dst/alu_data  input  1/1/3/4/16x32  ALU writeback request.
REQ-009 SHALL have port alu_ready  output  1  ALU request granted this cycle.
REQ-010 SHALL have ports ld_valid/ld_vec/ld_dst/ld_data  input  1/1/4/16x32  load-unit writeback request.
REQ-011 SHALL have port ld_ready  output  1  load request granted this cycle.
REQ-012 SHALL have ports rf_we3/rf_ra3/rf_wd3/rf_selec_v_s_w/rf_cmd  output  1/4/16x32/1/3  registered register-file write port.
REQ-013 SHALL have ports busy_s/busy_v  output  15/16  scoreboard state.

Function
REQ-014 Handshake: request transfers when valid and ready are high in the same cycle; at most one grant per cycle.
REQ-015 Priority: ALU wins by default; load wins when its starve counter equals STARVE_LIMIT.
REQ-016 Starve counter: increments each cycle ld_valid is high and not granted; clears on load grant or ld_valid low; saturates at STARVE_LIMIT.
REQ-017 Write port latency: granted request appears on rf_* exactly one cycle after grant, rf_we3 high that cycle only.
REQ-018 When no grant occurs, rf_we3 SHALL be 0 next cycle; rf_wd3/rf_ra3 hold previous values.
REQ-019 ALU request with alu_vec=1 and alu_cmd=3'b101 is a scalar write: rf_selec_v_s_w=1, rf_cmd=101, scoreboard clears busy_s.
REQ-020 Load requests SHALL drive rf_cmd=3'b000; rf_selec_v_s_w equals the request's vec bit.
REQ-021 Scalar destination 15 (PC) is not writable: issue accepted without reservation; a write request to it is granted but rf_we3 stays 0.
REQ-022 issue_ready = issue_valid and destination not currently busy (no same-cycle bypass of a clearing bit).
REQ-023 Busy bit set on accepted issue; cleared in the cycle rf_we3 for that register is asserted.
REQ-024 Set and clear of different registers in one cycle SHALL both take effect.
REQ-025 hazard: chk_vec selects busy_v or busy_s; scalar index 15 never hazards.
REQ-026 A write to a non-busy register SHALL still be performed; no busy bit changes.

Reset
REQ-027 On rst low: busy_s=0, busy_v=0, starve counter=0, rf_we3=0, rf_ra3=0, rf_wd3=0, rf_selec_v_s_w=0, rf_cmd=0.
REQ-028 alu_ready, ld_ready, issue_ready SHALL be 0 while rst is low.
REQ-029 Reset mid-operation discards any granted-but-unwritten request; no rf_we3 pulse after release until a new grant.

Structure
REQ-030 Package rf_ctrl_pkg SHALL hold NUM_VREG=16, NUM_SREG=15, LANES=16, CMD_VSCALAR=3'b101 and a lane-vector typedef (16x32).
REQ-031 Scoreboard (set/clear/hazard logic) SHALL be sub-module rf_scoreboard; arbitration and write-port register stay in the top.

Verification
REQ-032 Issue v3 then ALU write v3 data lane15=0x55 -> busy_v[3]=1, then rf_we3=1 with rf_ra3=3, rf_selec_v_s_w=1; busy_v[3]=0 same cycle.
REQ-033 alu_valid and ld_valid held high 6 cycles (STARVE_LIMIT=4) -> ALU granted cycles 0-3, load granted cycle 4.
REQ-034 ALU vec write cmd 101 to r2 after issue s2 -> rf_cmd=101, busy_s[2] clears, busy_v[2] unchanged.
REQ-035 Issue s7 while busy_s[7] set and clearing that cycle -> issue_ready=0; next cycle retry accepted.
REQ-036 Write request to scalar 15 -> granted, rf_we3 remains 0; chk_ra1=15 scalar gives hazard=0.
REQ-037 rst low the cycle after a grant -> no rf_we3 pulse, all busy bits 0 after release.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Register-file writeback control: shared types and constants.
// Used by the arbiter top and the scoreboard.
package rf_ctrl_pkg;

  localparam int NUM_VREG = 16;
  localparam int NUM_SREG = 15;
  localparam int LANES    = 16;
  localparam int XLEN     = 32;

  localparam logic [3:0] PC_IDX      = 4'd15;
  localparam logic [2:0] CMD_VSCALAR = 3'b101;
  localparam logic [2:0] CMD_LOAD    = 3'b000;

  typedef logic [3:0] reg_idx_t;

  typedef logic [LANES-1:0][XLEN-1:0] lane_vec_t;

  typedef struct packed {
    logic      vec;
    logic [2:0] cmd;
    reg_idx_t  dst;
    lane_vec_t data;
  } wb_req_t;

  // A vector-side request with the vscalar command targets a scalar reg.
  function automatic logic tgt_scalar(
    input logic       vec,
    input logic [2:0] cmd
  );
    return !vec || (cmd == CMD_VSCALAR);
  endfunction

  // One-hot scalar mask; index 15 (PC) shifts out to all zeros.
  function automatic logic [NUM_SREG-1:0] smask(
    input reg_idx_t i
  );
    return NUM_SREG'(1) << i;
  endfunction

  function automatic logic [NUM_VREG-1:0] vmask(
    input reg_idx_t i
  );
    return NUM_VREG'(1) << i;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: reserve on issue, release on writeback.
// Also answers read-operand hazard queries.
module rf_scoreboard
  import rf_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_vec,
  input  reg_idx_t            issue_dst,
  output logic                issue_ready,
  input  logic                clr_valid,
  input  logic                clr_scalar,
  input  reg_idx_t            clr_dst,
  input  logic                chk_vec,
  input  reg_idx_t            chk_ra1,
  input  reg_idx_t            chk_ra2,
  output logic                hazard,
  output logic [NUM_SREG-1:0] busy_s,
  output logic [NUM_VREG-1:0] busy_v
);

  logic                issue_free;
  logic [NUM_SREG-1:0] set_s;
  logic [NUM_SREG-1:0] clr_s;
  logic [NUM_VREG-1:0] set_v;
  logic [NUM_VREG-1:0] clr_v;

  // Destination is free when its busy bit is clear; PC is always free.
  always_comb begin
    issue_free = 1'b0;
    if (issue_vec) begin
      issue_free = ~|(busy_v & vmask(issue_dst));
    end else begin
      issue_free = ~|(busy_s & smask(issue_dst));
    end
  end

  assign issue_ready = rst & issue_valid & issue_free;

  // Decode the set and clear masks for this cycle.
  always_comb begin
    set_s = '0;
    set_v = '0;
    clr_s = '0;
    clr_v = '0;
    if (issue_ready) begin
      if (issue_vec) begin
        set_v = vmask(issue_dst);
      end else begin
        set_s = smask(issue_dst);
      end
    end
    if (clr_valid) begin
      if (clr_scalar) begin
        clr_s = smask(clr_dst);
      end else begin
        clr_v = vmask(clr_dst);
      end
    end
  end

  // Busy state; a fresh reservation wins over a release of the same reg.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_s <= '0;
      busy_v <= '0;
    end else begin
      busy_s <= (busy_s & ~clr_s) | set_s;
      busy_v <= (busy_v & ~clr_v) | set_v;
    end
  end

  // Hazard when either queried source is reserved.
  always_comb begin
    hazard = 1'b0;
    if (chk_vec) begin
      hazard = |(busy_v & (vmask(chk_ra1) | vmask(chk_ra2)));
    end else begin
      hazard = |(busy_s & (smask(chk_ra1) | smask(chk_ra2)));
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between ALU and load unit with a starvation guard.
// Drives a registered register-file write port and the scoreboard.
module regfile_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_vec,
  input  logic [3:0]          issue_dst,
  output logic                issue_ready,
  input  logic                chk_vec,
  input  logic [3:0]          chk_ra1,
  input  logic [3:0]          chk_ra2,
  output logic                hazard,
  input  logic                alu_valid,
  input  logic                alu_vec,
  input  logic [2:0]          alu_cmd,
  input  logic [3:0]          alu_dst,
  input  lane_vec_t           alu_data,
  output logic                alu_ready,
  input  logic                ld_valid,
  input  logic                ld_vec,
  input  logic [3:0]          ld_dst,
  input  lane_vec_t           ld_data,
  output logic                ld_ready,
  output logic                rf_we3,
  output logic [3:0]          rf_ra3,
  output lane_vec_t           rf_wd3,
  output logic                rf_selec_v_s_w,
  output logic [2:0]          rf_cmd,
  output logic [NUM_SREG-1:0] busy_s,
  output logic [NUM_VREG-1:0] busy_v
);

  localparam int CW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q;
  logic          ld_force;
  logic          alu_gnt;
  logic          ld_gnt;
  wb_req_t       req;
  logic          req_scalar;
  logic          req_wr;

  assign ld_force = ld_valid && (starve_q == LIM);
  assign alu_gnt  = rst && alu_valid && !ld_force;
  assign ld_gnt   = rst && ld_valid && (ld_force || !alu_valid);

  assign alu_ready = alu_gnt;
  assign ld_ready  = ld_gnt;

  // Count consecutive lost cycles of a pending load, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (!ld_valid || ld_gnt) begin
      starve_q <= '0;
    end else if (starve_q != LIM) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  // Select the winning request's fields.
  always_comb begin
    req = '0;
    unique case (1'b1)
      alu_gnt: begin
        req.vec  = alu_vec;
        req.cmd  = alu_cmd;
        req.dst  = alu_dst;
        req.data = alu_data;
      end
      ld_gnt: begin
        req.vec  = ld_vec;
        req.cmd  = CMD_LOAD;
        req.dst  = ld_dst;
        req.data = ld_data;
      end
      default: ;
    endcase
  end

  assign req_scalar = tgt_scalar(req.vec, req.cmd);

  // A grant to scalar PC is swallowed: no write, no busy change.
  assign req_wr = (alu_gnt || ld_gnt) &&
                  !(req_scalar && (req.dst == PC_IDX));

  // Write port register; data fields hold when nothing is written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we3         <= 1'b0;
      rf_ra3         <= '0;
      rf_wd3         <= '0;
      rf_selec_v_s_w <= 1'b0;
      rf_cmd         <= '0;
    end else begin
      rf_we3 <= req_wr;
      if (req_wr) begin
        rf_ra3         <= req.dst;
        rf_wd3         <= req.data;
        rf_selec_v_s_w <= req.vec;
        rf_cmd         <= req.cmd;
      end
    end
  end

  rf_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_vec   (issue_vec),
    .issue_dst   (issue_dst),
    .issue_ready (issue_ready),
    .clr_valid   (req_wr),
    .clr_scalar  (req_scalar),
    .clr_dst     (req.dst),
    .chk_vec     (chk_vec),
    .chk_ra1     (chk_ra1),
    .chk_ra2     (chk_ra2),
    .hazard      (hazard),
    .busy_s      (busy_s),
    .busy_v      (busy_v)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random
// traffic against a behavioural model of the writeback rules.
module tb_regfile_wb_arbiter;
  import rf_ctrl_pkg::*;

  localparam int LIM = 4;

  logic        clk, rst;
  logic        issue_valid, issue_vec, issue_ready;
  logic [3:0]  issue_dst;
  logic        chk_vec, hazard;
  logic [3:0]  chk_ra1, chk_ra2;
  logic        alu_valid, alu_vec, alu_ready;
  logic [2:0]  alu_cmd;
  logic [3:0]  alu_dst;
  lane_vec_t   alu_data;
  logic        ld_valid, ld_vec, ld_ready;
  logic [3:0]  ld_dst;
  lane_vec_t   ld_data;
  logic        rf_we3, rf_selec_v_s_w;
  logic [3:0]  rf_ra3;
  lane_vec_t   rf_wd3;
  logic [2:0]  rf_cmd;
  logic [14:0] busy_s;
  logic [15:0] busy_v;

  int vectors = 0;
  int errs = 0;

  bit        bs[16];
  bit        bv[16];
  int        starve;
  bit        m_we;
  logic [3:0] m_ra;
  lane_vec_t m_wd;
  bit        m_sel;
  logic [2:0] m_cmd;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_vec(issue_vec),
    .issue_dst(issue_dst), .issue_ready(issue_ready),
    .chk_vec(chk_vec), .chk_ra1(chk_ra1), .chk_ra2(chk_ra2),
    .hazard(hazard),
    .alu_valid(alu_valid), .alu_vec(alu_vec), .alu_cmd(alu_cmd),
    .alu_dst(alu_dst), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_vec(ld_vec), .ld_dst(ld_dst),
    .ld_data(ld_data), .ld_ready(ld_ready),
    .rf_we3(rf_we3), .rf_ra3(rf_ra3), .rf_wd3(rf_wd3),
    .rf_selec_v_s_w(rf_selec_v_s_w), .rf_cmd(rf_cmd),
    .busy_s(busy_s), .busy_v(busy_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // 0 = no grant, 1 = ALU, 2 = load
  function automatic int winner();
    if (!rst) return 0;
    if (ld_valid && starve == LIM) return 2;
    if (alu_valid) return 1;
    if (ld_valid) return 2;
    return 0;
  endfunction

  function automatic bit m_iss();
    if (!rst || !issue_valid) return 1'b0;
    return issue_vec ? !bv[issue_dst] : !bs[issue_dst];
  endfunction

  function automatic bit m_haz();
    if (chk_vec) return bv[chk_ra1] || bv[chk_ra2];
    return bs[chk_ra1] || bs[chk_ra2];
  endfunction

  function automatic logic [14:0] m_bs();
    logic [14:0] r;
    for (int i = 0; i < 15; i++) r[i] = bs[i];
    return r;
  endfunction

  function automatic logic [15:0] m_bv();
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = bv[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      bs[i] = 1'b0;
      bv[i] = 1'b0;
    end
    starve = 0;
    m_we = 1'b0;
    m_ra = '0;
    m_wd = '0;
    m_sel = 1'b0;
    m_cmd = '0;
  endtask

  // Apply the effect of the coming clock edge to the model.
  task automatic model_edge();
    int w;
    bit acc, vec, sc;
    logic [2:0] cmd;
    logic [3:0] dst;
    lane_vec_t d;
    w = winner();
    acc = m_iss();
    if (!rst) begin
      model_reset();
      return;
    end
    if (ld_valid && w != 2)
      starve = (starve < LIM) ? starve + 1 : LIM;
    else
      starve = 0;
    m_we = 1'b0;
    vec = 1'b0; cmd = '0; dst = '0; d = '0;
    if (w == 1) begin
      vec = alu_vec; cmd = alu_cmd; dst = alu_dst; d = alu_data;
    end else if (w == 2) begin
      vec = ld_vec; cmd = 3'b000; dst = ld_dst; d = ld_data;
    end
    if (w != 0) begin
      sc = !vec || (cmd == 3'b101);
      if (!(sc && dst == 4'd15)) begin
        m_we = 1'b1;
        m_ra = dst;
        m_wd = d;
        m_sel = vec;
        m_cmd = cmd;
        if (sc) bs[dst] = 1'b0;
        else bv[dst] = 1'b0;
      end
    end
    if (acc) begin
      if (issue_vec) bv[issue_dst] = 1'b1;
      else if (issue_dst != 4'd15) bs[issue_dst] = 1'b1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 0; issue_vec = 0; issue_dst = 0;
    alu_valid = 0; alu_vec = 0; alu_cmd = 0; alu_dst = 0;
    alu_data = '0;
    ld_valid = 0; ld_vec = 0; ld_dst = 0; ld_data = '0;
    chk_vec = 0; chk_ra1 = 0; chk_ra2 = 0;
  endtask

  task automatic alu_req(input bit v, input logic [2:0] c,
                         input logic [3:0] d, input lane_vec_t x);
    alu_valid = 1; alu_vec = v; alu_cmd = c;
    alu_dst = d; alu_data = x;
  endtask

  task automatic issue(input bit v, input logic [3:0] d);
    issue_valid = 1; issue_vec = v; issue_dst = d;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    issue_valid = 1; alu_valid = 1; ld_valid = 1;
    model_reset();
    @(negedge clk);
    #1;
    vectors++;
    if ({issue_ready, alu_ready, ld_ready} !== 3'b000) begin
      errs++;
      $display("FAIL rst_ready got=%b want=000",
               {issue_ready, alu_ready, ld_ready});
    end
    vectors++;
    if ({busy_s, busy_v} !== 31'd0) begin
      errs++;
      $display("FAIL rst_busy got=%h want=0", {busy_s, busy_v});
    end
    vectors++;
    if ({rf_we3, rf_ra3, rf_selec_v_s_w, rf_cmd} !== 9'd0 ||
        rf_wd3 !== '0) begin
      errs++;
      $display("FAIL rst_rf we=%b ra=%h cmd=%h want all 0",
               rf_we3, rf_ra3, rf_cmd);
    end
    @(negedge clk);
    rst = 1;
    idle();
    tick();
    vectors++;
    if (rf_we3 !== 1'b0) begin
      errs++;
      $display("FAIL rst_release_we got=%b want=0", rf_we3);
    end
  endtask

  task automatic test_vec_write();
    lane_vec_t d;
    d = '0;
    d[15] = 32'h55;
    idle();
    issue(1, 4'd3);
    #1;
    vectors++;
    if (issue_ready !== 1'b1) begin
      errs++;
      $display("FAIL vw_issue got=%b want=1", issue_ready);
    end
    tick();
    idle();
    vectors++;
    if (busy_v[3] !== 1'b1) begin
      errs++;
      $display("FAIL vw_busy_set got=%b want=1", busy_v[3]);
    end
    alu_req(1, 3'b010, 4'd3, d);
    #1;
    vectors++;
    if (alu_ready !== 1'b1) begin
      errs++;
      $display("FAIL vw_alu_ready got=%b want=1", alu_ready);
    end
    tick();
    idle();
    vectors++;
    if ({rf_we3, rf_ra3, rf_selec_v_s_w, rf_cmd} !==
        {1'b1, 4'd3, 1'b1, 3'b010}) begin
      errs++;
      $display("FAIL vw_port we=%b ra=%h sel=%b cmd=%h want 1/3/1/2",
               rf_we3, rf_ra3, rf_selec_v_s_w, rf_cmd);
    end
    vectors++;
    if (rf_wd3[15] !== 32'h55 || busy_v[3] !== 1'b0) begin
      errs++;
      $display("FAIL vw_data lane15=%h busy=%b want 55/0",
               rf_wd3[15], busy_v[3]);
    end
    tick();
    vectors++;
    if ({rf_we3, rf_ra3} !== {1'b0, 4'd3} ||
        rf_wd3[15] !== 32'h55) begin
      errs++;
      $display("FAIL vw_hold we=%b ra=%h lane15=%h want 0/3/55",
               rf_we3, rf_ra3, rf_wd3[15]);
    end
  endtask

  task automatic test_starve();
    idle();
    tick();
    for (int i = 0; i < 6; i++) begin
      alu_req(0, 3'b001, 4'(i), '0);
      ld_valid = 1; ld_vec = 0; ld_dst = 4'd9;
      #1;
      vectors++;
      if ({alu_ready, ld_ready} !== {i != 4, i == 4}) begin
        errs++;
        $display("FAIL starve_c%0d alu=%b ld=%b want %b%b",
                 i, alu_ready, ld_ready, i != 4, i == 4);
      end
      tick();
      if (i == 4) begin
        vectors++;
        if ({rf_we3, rf_ra3, rf_cmd} !== {1'b1, 4'd9, 3'b000}) begin
          errs++;
          $display("FAIL starve_ld_port we=%b ra=%h cmd=%h want 1/9/0",
                   rf_we3, rf_ra3, rf_cmd);
        end
      end
    end
    idle();
    tick();
  endtask

  task automatic test_vscalar();
    idle();
    issue(1, 4'd2);
    tick();
    issue(0, 4'd2);
    tick();
    idle();
    vectors++;
    if ({busy_s[2], busy_v[2]} !== 2'b11) begin
      errs++;
      $display("FAIL vs_setup got=%b want=11", {busy_s[2], busy_v[2]});
    end
    alu_req(1, 3'b101, 4'd2, '0);
    tick();
    idle();
    vectors++;
    if ({rf_we3, rf_selec_v_s_w, rf_cmd} !== {1'b1, 1'b1, 3'b101}) begin
      errs++;
      $display("FAIL vs_port we=%b sel=%b cmd=%h want 1/1/5",
               rf_we3, rf_selec_v_s_w, rf_cmd);
    end
    vectors++;
    if ({busy_s[2], busy_v[2]} !== 2'b01) begin
      errs++;
      $display("FAIL vs_busy got=%b want=01", {busy_s[2], busy_v[2]});
    end
    ld_valid = 1; ld_vec = 1; ld_dst = 4'd2;
    tick();
    idle();
    vectors++;
    if ({rf_we3, rf_selec_v_s_w, rf_cmd, busy_v[2]} !==
        {1'b1, 1'b1, 3'b000, 1'b0}) begin
      errs++;
      $display("FAIL vs_load we=%b sel=%b cmd=%h busy=%b want 1/1/0/0",
               rf_we3, rf_selec_v_s_w, rf_cmd, busy_v[2]);
    end
  endtask

  task automatic test_issue_retry();
    idle();
    issue(0, 4'd7);
    tick();
    alu_req(0, 3'b000, 4'd7, '0);
    issue(0, 4'd7);
    #1;
    vectors++;
    if ({issue_ready, alu_ready} !== 2'b01) begin
      errs++;
      $display("FAIL retry_block iss=%b alu=%b want 0/1",
               issue_ready, alu_ready);
    end
    tick();
    alu_valid = 0;
    vectors++;
    if ({busy_s[7], issue_ready} !== 2'b01) begin
      errs++;
      $display("FAIL retry_accept busy=%b iss=%b want 0/1",
               busy_s[7], issue_ready);
    end
    tick();
    alu_req(0, 3'b000, 4'd7, '0);
    issue(1, 4'd5);
    tick();
    idle();
    vectors++;
    if ({busy_s[7], busy_v[5]} !== 2'b01) begin
      errs++;
      $display("FAIL set_clr_pair s7=%b v5=%b want 0/1",
               busy_s[7], busy_v[5]);
    end
    ld_valid = 1; ld_vec = 1; ld_dst = 4'd5;
    tick();
    idle();
  endtask

  task automatic test_pc();
    idle();
    issue(0, 4'd15);
    #1;
    vectors++;
    if (issue_ready !== 1'b1) begin
      errs++;
      $display("FAIL pc_issue got=%b want=1", issue_ready);
    end
    tick();
    issue(0, 4'd6);
    alu_req(0, 3'b011, 4'd15, '1);
    #1;
    vectors++;
    if ({alu_ready, busy_s} !== {1'b1, 15'd0}) begin
      errs++;
      $display("FAIL pc_grant alu=%b busy_s=%h want 1/0",
               alu_ready, busy_s);
    end
    tick();
    idle();
    vectors++;
    if (rf_we3 !== 1'b0) begin
      errs++;
      $display("FAIL pc_no_write got=%b want=0", rf_we3);
    end
    chk_vec = 0; chk_ra1 = 4'd15; chk_ra2 = 4'd1;
    #1;
    vectors++;
    if (hazard !== 1'b0) begin
      errs++;
      $display("FAIL pc_hazard got=%b want=0", hazard);
    end
    chk_ra2 = 4'd6;
    #1;
    vectors++;
    if (hazard !== 1'b1) begin
      errs++;
      $display("FAIL s6_hazard got=%b want=1", hazard);
    end
    chk_vec = 1;
    #1;
    vectors++;
    if (hazard !== 1'b0) begin
      errs++;
      $display("FAIL v6_hazard got=%b want=0", hazard);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    issue(1, 4'd4);
    tick();
    alu_req(1, 3'b000, 4'd1, '1);
    issue(1, 4'd9);
    model_edge();
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    @(negedge clk);
    vectors++;
    if ({rf_we3, alu_ready, issue_ready} !== 3'b000) begin
      errs++;
      $display("FAIL mid_rst we=%b alu=%b iss=%b want 000",
               rf_we3, alu_ready, issue_ready);
    end
    @(negedge clk);
    rst = 1;
    idle();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({rf_we3, busy_s, busy_v} !== 32'd0) begin
        errs++;
        $display("FAIL mid_release_c%0d we=%b bs=%h bv=%h want 0",
                 i, rf_we3, busy_s, busy_v);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int w;
    for (int n = 0; n < 400; n++) begin
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_vec = $urandom_range(0, 1);
      issue_dst = 4'($urandom_range(0, 15));
      alu_valid = ($urandom_range(0, 2) != 0);
      alu_vec = $urandom_range(0, 1);
      alu_cmd = ($urandom_range(0, 2) == 0) ? 3'b101 : 3'($urandom);
      alu_dst = 4'($urandom_range(0, 15));
      ld_valid = ($urandom_range(0, 2) != 0);
      ld_vec = $urandom_range(0, 1);
      ld_dst = 4'($urandom_range(0, 15));
      for (int l = 0; l < 16; l++) begin
        alu_data[l] = $urandom;
        ld_data[l] = $urandom;
      end
      chk_vec = $urandom_range(0, 1);
      chk_ra1 = 4'($urandom_range(0, 15));
      chk_ra2 = 4'($urandom_range(0, 15));
      #1;
      w = winner();
      vectors++;
      if ({issue_ready, alu_ready, ld_ready, hazard} !==
          {m_iss(), w == 1, w == 2, m_haz()}) begin
        errs++;
        $display("FAIL rnd_comb n=%0d got=%b want=%b", n,
                 {issue_ready, alu_ready, ld_ready, hazard},
                 {m_iss(), w == 1, w == 2, m_haz()});
      end
      vectors++;
      if (busy_s !== m_bs() || busy_v !== m_bv()) begin
        errs++;
        $display("FAIL rnd_busy n=%0d got=%h/%h want=%h/%h", n,
                 busy_s, busy_v, m_bs(), m_bv());
      end
      vectors++;
      if ({rf_we3, rf_ra3, rf_selec_v_s_w, rf_cmd} !==
          {m_we, m_ra, m_sel, m_cmd} || rf_wd3 !== m_wd) begin
        errs++;
        $display("FAIL rnd_port n=%0d got=%b/%h/%b/%h want=%b/%h/%b/%h",
                 n, rf_we3, rf_ra3, rf_selec_v_s_w, rf_cmd,
                 m_we, m_ra, m_sel, m_cmd);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_vec_write();
    test_starve();
    test_vscalar();
    test_issue_retry();
    test_pc();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
